// File: rtl/num_stepper_pkg.sv
// num_stepper_pkg
//   Shared definitions for the num_stepper block: number width, the
//   MANUAL/AUTO state encoding and the default timing parameters.
package num_stepper_pkg;

    localparam int NUM_W           = 5;
    localparam int DEF_DB_CYCLES   = 1000000;
    localparam int DEF_AUTO_CYCLES = 50000000;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

endpackage

// File: rtl/num_stepper_btn_debounce.sv
// btn_debounce
//   Two-flop synchronizer, level debouncer and rising-edge press pulse for
//   one raw mechanical button.
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous active-low reset
//     raw    - raw, bouncy, asynchronous button input
//     press  - one-cycle pulse in the cycle the debounced level goes high
module btn_debounce
    import num_stepper_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int            CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync_0;
    logic          sync_1;
    logic          level;
    logic [CW-1:0] cnt;

    // The level flips only after DB_CYCLES consecutive cycles of
    // disagreement; one agreeing cycle restarts the count. The press pulse
    // is registered together with the level so it lines up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_0 <= raw;
            sync_1 <= sync_0;
            press  <= 1'b0;
            if (sync_1 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_1;
                    cnt   <= '0;
                    press <= sync_1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/num_stepper.sv
// num_stepper
//   5-bit modulo-32 counter driven by up/down/load buttons (MANUAL mode) or
//   by a periodic tick (AUTO mode, selected by the sw_auto switch).
//   Ports:
//     clk       - system clock, rising edge
//     rst_n     - asynchronous active-low reset
//     btn_up    - raw increment button
//     btn_down  - raw decrement button
//     btn_load  - raw load button
//     sw_val    - value loaded on a load press
//     sw_auto   - raw mode switch, 1 = AUTO, 0 = MANUAL
//     num       - registered current number
//     num_chg   - one-cycle pulse when num shows a newly committed value
//     auto_mode - high while the FSM is in AUTO
module num_stepper
    import num_stepper_pkg::*;
#(
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int AUTO_CYCLES = DEF_AUTO_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_load,
    input  logic [NUM_W-1:0] sw_val,
    input  logic             sw_auto,
    output logic [NUM_W-1:0] num,
    output logic             num_chg,
    output logic             auto_mode
);

    localparam int            TW        = $clog2(AUTO_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(AUTO_CYCLES - 1);

    logic up_p;
    logic down_p;
    logic load_p;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk(clk), .rst_n(rst_n), .raw(btn_up), .press(up_p)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .clk(clk), .rst_n(rst_n), .raw(btn_down), .press(down_p)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
        .clk(clk), .rst_n(rst_n), .raw(btn_load), .press(load_p)
    );

    // Mode switch is a clean slide switch: synchronize, no debounce.
    logic auto_s0;
    logic auto_s1;

    state_t           state_q;
    state_t           state_d;
    logic [TW-1:0]    tick_q;
    logic [TW-1:0]    tick_d;
    logic [NUM_W-1:0] num_d;
    logic             chg_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_s0   <= 1'b0;
            auto_s1   <= 1'b0;
            state_q   <= MANUAL;
            tick_q    <= '0;
            num       <= '0;
            num_chg   <= 1'b0;
            auto_mode <= 1'b0;
        end else begin
            auto_s0   <= sw_auto;
            auto_s1   <= auto_s0;
            state_q   <= state_d;
            tick_q    <= tick_d;
            num       <= num_d;
            num_chg   <= chg_d;
            auto_mode <= (state_d == AUTO);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MANUAL:  if (auto_s1)  state_d = AUTO;
            AUTO:    if (!auto_s1) state_d = MANUAL;
            default: state_d = MANUAL;
        endcase
    end

    // The tick counter is held at zero outside AUTO, so entering AUTO always
    // starts a full period. Load has priority over everything else.
    always_comb begin
        num_d  = num;
        chg_d  = 1'b0;
        tick_d = tick_q;
        if (state_q == MANUAL) begin
            tick_d = '0;
            if (load_p) begin
                num_d = sw_val;
                chg_d = 1'b1;
            end else if (up_p && !down_p) begin
                num_d = num + 1'b1;
                chg_d = 1'b1;
            end else if (down_p && !up_p) begin
                num_d = num - 1'b1;
                chg_d = 1'b1;
            end
        end else begin
            if (load_p) begin
                num_d  = sw_val;
                chg_d  = 1'b1;
                tick_d = '0;
            end else if (tick_q == TICK_LAST) begin
                num_d  = num + 1'b1;
                chg_d  = 1'b1;
                tick_d = '0;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_num_stepper.sv
// tb_num_stepper
//   Directed bench for num_stepper with DB_CYCLES=4, AUTO_CYCLES=8.
module tb_num_stepper;

    localparam int DB = 4;
    localparam int AC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_load = 1'b0;
    logic [4:0] sw_val = 5'd0;
    logic       sw_auto = 1'b0;
    logic [4:0] num;
    logic       num_chg;
    logic       auto_mode;

    int n_checks = 0;
    int n_pass   = 0;
    int chg_cnt  = 0;

    always #5 clk = ~clk;

    num_stepper #(.DB_CYCLES(DB), .AUTO_CYCLES(AC)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
        .sw_val(sw_val), .sw_auto(sw_auto),
        .num(num), .num_chg(num_chg), .auto_mode(auto_mode)
    );

    // Advance n falling edges, counting num_chg pulses seen on the way.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (num_chg === 1'b1) chg_cnt++;
        end
    endtask

    task automatic press_load(input logic [4:0] v);
        sw_val = v;
        btn_load = 1'b1;
        step(12);
        btn_load = 1'b0;
        step(8);
    endtask

    task automatic press_up_down(input logic up, input logic down);
        btn_up = up;
        btn_down = down;
        step(12);
        btn_up = 1'b0;
        btn_down = 1'b0;
        step(8);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        n_checks++;
        if (num !== 5'd0) $display("FAIL reset_num: got %0d want 0", num);
        else n_pass++;
        n_checks++;
        if (num_chg !== 1'b0 || auto_mode !== 1'b0)
            $display("FAIL reset_flags: got chg=%b auto=%b want 0/0", num_chg, auto_mode);
        else n_pass++;
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_debounce;
        chg_cnt = 0;
        btn_up = 1'b1;
        step(6);
        n_checks++;
        if (num !== 5'd0) $display("FAIL up_early: got %0d want 0 after 6 cycles", num);
        else n_pass++;
        step(1);
        n_checks++;
        if (num !== 5'd1) $display("FAIL up_latency: got %0d want 1 after 7 cycles", num);
        else n_pass++;
        step(5);
        btn_up = 1'b0;
        step(8);
        n_checks++;
        if (num !== 5'd1 || chg_cnt !== 1)
            $display("FAIL up_hold: got num=%0d chg=%0d want 1/1", num, chg_cnt);
        else n_pass++;
        // Two-cycle glitch never survives the debounce window.
        chg_cnt = 0;
        btn_up = 1'b1;
        step(2);
        btn_up = 1'b0;
        step(10);
        n_checks++;
        if (num !== 5'd1 || chg_cnt !== 0)
            $display("FAIL glitch: got num=%0d chg=%0d want 1/0", num, chg_cnt);
        else n_pass++;
    endtask

    task automatic test_wrap;
        press_load(5'd31);
        n_checks++;
        if (num !== 5'd31) $display("FAIL load31: got %0d want 31", num);
        else n_pass++;
        chg_cnt = 0;
        press_up_down(1'b1, 1'b0);
        n_checks++;
        if (num !== 5'd0 || chg_cnt !== 1)
            $display("FAIL wrap_up: got num=%0d chg=%0d want 0/1", num, chg_cnt);
        else n_pass++;
        chg_cnt = 0;
        press_up_down(1'b0, 1'b1);
        n_checks++;
        if (num !== 5'd31 || chg_cnt !== 1)
            $display("FAIL wrap_down: got num=%0d chg=%0d want 31/1", num, chg_cnt);
        else n_pass++;
    endtask

    task automatic test_load;
        chg_cnt = 0;
        press_load(5'd30);
        n_checks++;
        if (num !== 5'd30 || chg_cnt !== 1)
            $display("FAIL load30: got num=%0d chg=%0d want 30/1", num, chg_cnt);
        else n_pass++;
        chg_cnt = 0;
        press_load(5'd30);
        n_checks++;
        if (num !== 5'd30 || chg_cnt !== 1)
            $display("FAIL load_same: got num=%0d chg=%0d want 30/1", num, chg_cnt);
        else n_pass++;
        chg_cnt = 0;
        press_up_down(1'b1, 1'b1);
        n_checks++;
        if (num !== 5'd30 || chg_cnt !== 0)
            $display("FAIL up_down_same: got num=%0d chg=%0d want 30/0", num, chg_cnt);
        else n_pass++;
    endtask

    task automatic test_auto;
        press_load(5'd0);
        sw_auto = 1'b1;
        step(3);
        n_checks++;
        if (auto_mode !== 1'b1 || num !== 5'd0)
            $display("FAIL auto_enter: got auto=%b num=%0d want 1/0", auto_mode, num);
        else n_pass++;
        step(7);
        n_checks++;
        if (num !== 5'd0) $display("FAIL auto_early: got %0d want 0", num);
        else n_pass++;
        step(1);
        n_checks++;
        if (num !== 5'd1 || num_chg !== 1'b1)
            $display("FAIL auto_tick1: got num=%0d chg=%b want 1/1", num, num_chg);
        else n_pass++;
        step(8);
        n_checks++;
        if (num !== 5'd2) $display("FAIL auto_tick2: got %0d want 2", num);
        else n_pass++;
        // Up press in AUTO must not add steps on top of the ticks.
        chg_cnt = 0;
        btn_up = 1'b1;
        step(12);
        btn_up = 1'b0;
        step(8);
        n_checks++;
        if (num !== 5'd4 || chg_cnt !== 2)
            $display("FAIL auto_up_ignored: got num=%0d chg=%0d want 4/2", num, chg_cnt);
        else n_pass++;
        step(212);
        n_checks++;
        if (num !== 5'd31) $display("FAIL auto_31: got %0d want 31", num);
        else n_pass++;
        step(8);
        n_checks++;
        if (num !== 5'd0) $display("FAIL auto_wrap: got %0d want 0", num);
        else n_pass++;
        // Load mid-period restarts the period.
        step(4);
        sw_val = 5'd5;
        btn_load = 1'b1;
        step(7);
        btn_load = 1'b0;
        n_checks++;
        if (num !== 5'd5) $display("FAIL auto_load: got %0d want 5", num);
        else n_pass++;
        step(7);
        n_checks++;
        if (num !== 5'd5) $display("FAIL auto_load_hold: got %0d want 5", num);
        else n_pass++;
        step(1);
        n_checks++;
        if (num !== 5'd6) $display("FAIL auto_after_load: got %0d want 6", num);
        else n_pass++;
        sw_auto = 1'b0;
        step(4);
        n_checks++;
        if (auto_mode !== 1'b0) $display("FAIL auto_exit: got %b want 0", auto_mode);
        else n_pass++;
        step(8);
    endtask

    task automatic test_async_reset;
        press_load(5'd17);
        n_checks++;
        if (num !== 5'd17) $display("FAIL load17: got %0d want 17", num);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (num !== 5'd0 || num_chg !== 1'b0 || auto_mode !== 1'b0)
            $display("FAIL async_reset: got num=%0d chg=%b auto=%b want 0/0/0",
                     num, num_chg, auto_mode);
        else n_pass++;
        // Button held through reset release still needs a full debounce.
        btn_up = 1'b1;
        step(2);
        rst_n = 1'b1;
        chg_cnt = 0;
        step(6);
        n_checks++;
        if (num !== 5'd0 || chg_cnt !== 0)
            $display("FAIL held_early: got num=%0d chg=%0d want 0/0", num, chg_cnt);
        else n_pass++;
        step(1);
        n_checks++;
        if (num !== 5'd1) $display("FAIL held_press: got %0d want 1", num);
        else n_pass++;
        btn_up = 1'b0;
        step(8);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_load();
        test_auto();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
